// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory arbiter: port IDs, read-owner state encoding, default widths.
package dmem_pkg;

    localparam int DEF_ADDR_W     = 10;
    localparam int DEF_DATA_W     = 32;
    localparam int DEF_STARVE_MAX = 4;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DBG = 1'b1;

    // State records which port owns the read currently returning from RAM.
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_CPU_RD = 2'd1;
    localparam logic [1:0] ST_DBG_RD = 2'd2;

endpackage

// File: rtl/dmem_starve_ctr.sv
// Counts consecutive cycles the debug port waits unserved; flags a forced grant at STARVE_MAX.
module dmem_starve_ctr
    import dmem_pkg::*;
#(
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic force_dbg
);

    localparam logic [3:0] MAX = 4'(STARVE_MAX);

    logic [3:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= 4'd0;
        end else if (clr) begin
            cnt <= 4'd0;
        end else if (inc && (cnt != MAX)) begin
            cnt <= cnt + 4'd1;
        end
    end

    assign force_dbg = (cnt == MAX);

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter (CPU priority, DBG starvation guard, DBG halt-lock) in front of a single-port sync RAM.
// Grants are combinational; read data and rvalid appear the cycle after the read grant.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_ready,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,

    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    input  logic              dbg_lock,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,

    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);

    logic              force_dbg;
    logic              sel;
    logic              any_gnt;
    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] din_q;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic [DATA_W-1:0] dbg_rdata_q;

    dmem_starve_ctr #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve (
        .clk       (clk),
        .rst       (rst),
        .inc       (dbg_req & ~dbg_gnt & ~dbg_lock),
        .clr       (dbg_gnt | ~dbg_req),
        .force_dbg (force_dbg)
    );

    // Grants are masked by rst so nothing reaches the RAM while reset is held.
    always_comb begin
        cpu_gnt = 1'b0;
        dbg_gnt = 1'b0;
        if (!rst) begin
            if (dbg_lock) begin
                dbg_gnt = dbg_req;
            end else if (force_dbg && dbg_req) begin
                dbg_gnt = 1'b1;
            end else if (cpu_req) begin
                cpu_gnt = 1'b1;
            end else if (dbg_req) begin
                dbg_gnt = 1'b1;
            end
        end
    end

    assign any_gnt   = cpu_gnt | dbg_gnt;
    assign sel       = dbg_gnt ? PORT_DBG : PORT_CPU;
    assign cpu_ready = ~rst & (~cpu_req | cpu_gnt);

    always_comb begin
        mem_we   = 1'b0;
        mem_addr = addr_q;
        mem_din  = din_q;
        if (any_gnt) begin
            mem_we   = (sel == PORT_DBG) ? dbg_we    : cpu_we;
            mem_addr = (sel == PORT_DBG) ? dbg_addr  : cpu_addr;
            mem_din  = (sel == PORT_DBG) ? dbg_wdata : cpu_wdata;
        end
    end

    always_comb begin
        state_nxt = ST_IDLE;
        if (cpu_gnt && !cpu_we) begin
            state_nxt = ST_CPU_RD;
        end else if (dbg_gnt && !dbg_we) begin
            state_nxt = ST_DBG_RD;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            addr_q      <= '0;
            din_q       <= '0;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
        end else begin
            state  <= state_nxt;
            addr_q <= mem_addr;
            din_q  <= mem_din;
            if (cpu_rvalid) begin
                cpu_rdata_q <= mem_dout;
            end
            if (dbg_rvalid) begin
                dbg_rdata_q <= mem_dout;
            end
        end
    end

    // RAM output register already provides the flop; the owner sees douta directly
    // in the return cycle and a captured copy afterwards.
    assign cpu_rvalid = (state == ST_CPU_RD);
    assign dbg_rvalid = (state == ST_DBG_RD);
    assign cpu_rdata  = cpu_rvalid ? mem_dout : cpu_rdata_q;
    assign dbg_rdata  = dbg_rvalid ? mem_dout : dbg_rdata_q;

endmodule
